// File: rtl/pipeline_control_if.sv
// pipeline_control_if: fetch-side handshake and status bundle for the pipeline controller
interface pipeline_control_if;
    logic        instr_valid_i;
    logic [31:0] instr_i;
    logic        exec_i;
    logic        instr_ready_o;
    logic        issue_valid_o;
    logic [31:0] issue_instr_o;
    logic        stall_o;
    logic        flush_o;
    logic        busy_o;
    logic [3:0]  count_o;

    modport master (
        output instr_valid_i, instr_i, exec_i,
        input  instr_ready_o, issue_valid_o, issue_instr_o, stall_o, flush_o, busy_o, count_o
    );

    modport slave (
        input  instr_valid_i, instr_i, exec_i,
        output instr_ready_o, issue_valid_o, issue_instr_o, stall_o, flush_o, busy_o, count_o
    );
endinterface

// File: rtl/pipeline_control.sv
// pipeline_control: issue sequencer with multi-cycle multiply stall and post-PC-write flush
module pipeline_control #(
    parameter int MUL_CYCLES   = 4,
    parameter int FLUSH_CYCLES = 2
) (
    input logic               clk,
    input logic               rst_n,
    pipeline_control_if.slave bus
);
    localparam logic [31:0] NOP_INSTR = 32'hE320F000;
    localparam logic [1:0]  IDLE  = 2'd0;
    localparam logic [1:0]  MUL   = 2'd1;
    localparam logic [1:0]  FLUSH = 2'd2;

    logic [1:0]  state_q, state_d;
    logic [3:0]  count_q, count_d;
    logic        issue_valid_q, issue_valid_d;
    logic [31:0] issue_instr_q, issue_instr_d;
    logic        is_nop, is_mul, is_dp, transfer, go;

    // Classify the offered instruction, decide what to issue and where the sequencer goes next
    always_comb begin
        is_nop        = bus.instr_i[27:0] == 28'h320F000;
        is_mul        = bus.instr_i[27:26] == 2'b00 && !bus.instr_i[25] && bus.instr_i[7] && bus.instr_i[4];
        is_dp         = bus.instr_i[27:26] == 2'b00 && !is_nop && !is_mul;
        transfer      = bus.instr_valid_i && state_q == IDLE;
        go            = transfer && bus.exec_i && (is_mul || is_dp);
        issue_valid_d = transfer;
        issue_instr_d = go ? bus.instr_i : NOP_INSTR;
        state_d       = state_q;
        count_d       = count_q;
        if (state_q == IDLE) begin
            if (go && is_mul) begin
                state_d = MUL;
                count_d = 4'(MUL_CYCLES - 1);
            end else if (go && is_dp && bus.instr_i[15:12] == 4'hF) begin
                state_d = FLUSH;
                count_d = 4'(FLUSH_CYCLES);
            end
        end else if (count_q <= 4'd1) begin
            state_d = IDLE;
            count_d = 4'd0;
        end else begin
            count_d = count_q - 4'd1;
        end
    end

    // Sequencer state and issue slot registers, cleared asynchronously
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            count_q       <= 4'd0;
            issue_valid_q <= 1'b0;
            issue_instr_q <= NOP_INSTR;
        end else begin
            state_q       <= state_d;
            count_q       <= count_d;
            issue_valid_q <= issue_valid_d;
            issue_instr_q <= issue_instr_d;
        end
    end

    assign bus.instr_ready_o = state_q == IDLE;
    assign bus.stall_o       = state_q == MUL;
    assign bus.flush_o       = state_q == FLUSH;
    assign bus.busy_o        = bus.stall_o | bus.flush_o;
    assign bus.count_o       = count_q;
    assign bus.issue_valid_o = issue_valid_q;
    assign bus.issue_instr_o = issue_instr_q;
endmodule

// File: tb/tb_pipeline_control.sv
// tb_pipeline_control: directed and randomized checks against a cycle-timeline reference model
module tb_pipeline_control;
    localparam int MC = 4;
    localparam int FC = 2;
    localparam logic [31:0] NOPI = 32'hE320F000;

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    pipeline_control_if bus();

    pipeline_control #(.MUL_CYCLES(MC), .FLUSH_CYCLES(FC)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    always #5 clk = ~clk;

    int checks = 0;
    int fails = 0;
    // Model: the controller is occupied for every cycle number in [busy_from, free_at)
    int cyc = 0;
    int free_at = 0;
    bit kind_mul = 1'b0;
    logic exp_iv = 1'b0;
    logic [31:0] exp_ii = NOPI;

    logic [40:0] obs;
    assign obs = {bus.issue_valid_o, bus.issue_instr_o, bus.stall_o, bus.flush_o, bus.busy_o,
                  bus.instr_ready_o, bus.count_o};

    function automatic logic [40:0] expv();
        bit b;
        b = cyc < free_at;
        return {exp_iv, exp_ii, b && kind_mul, b && !kind_mul, b, !b, b ? 4'(free_at - cyc) : 4'd0};
    endfunction

    task automatic model_reset();
        free_at = cyc;
        exp_iv = 1'b0;
        exp_ii = NOPI;
    endtask

    task automatic drive(input bit v, input logic [31:0] ins, input bit ex);
        bit b, mul, nop, dp, xfer;
        bus.instr_valid_i = v;
        bus.instr_i = ins;
        bus.exec_i = ex;
        b = cyc < free_at;
        xfer = v && !b;
        nop = ins[27:0] == 28'h320F000;
        mul = (ins & 32'h0E000090) == 32'h00000090;
        dp = ins[27:26] == 2'b00 && !nop && !mul;
        exp_iv = xfer;
        exp_ii = (xfer && ex && (mul || dp)) ? ins : NOPI;
        if (xfer && ex && mul) begin
            kind_mul = 1'b1;
            free_at = cyc + MC;
        end else if (xfer && ex && dp && ins[15:12] == 4'hF) begin
            kind_mul = 1'b0;
            free_at = cyc + 1 + FC;
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic test_reset();
        bus.instr_valid_i = 1'b0;
        bus.instr_i = 32'h0;
        bus.exec_i = 1'b0;
        #1 rst_n = 1'b0;
        #1 model_reset();
        checks++;
        if (obs !== {1'b0, NOPI, 4'b0001, 4'd0}) begin
            fails++;
            $display("FAIL reset_async: got %h want %h", obs, {1'b0, NOPI, 4'b0001, 4'd0});
        end
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (obs !== expv()) begin
            fails++;
            $display("FAIL reset_held: got %h want %h", obs, expv());
        end
        rst_n = 1'b1;
    endtask

    task automatic test_add();
        drive(1'b1, 32'hE0821003, 1'b1);
        checks++;
        if (obs !== expv()) begin
            fails++;
            $display("FAIL add_model: got %h want %h", obs, expv());
        end
        checks++;
        if ({bus.issue_valid_o, bus.issue_instr_o, bus.instr_ready_o, bus.busy_o} !== {1'b1, 32'hE0821003, 2'b10}) begin
            fails++;
            $display("FAIL add_issue: got %b %h ready %b busy %b want 1 e0821003 ready 1 busy 0",
                     bus.issue_valid_o, bus.issue_instr_o, bus.instr_ready_o, bus.busy_o);
        end
    endtask

    task automatic test_mul();
        drive(1'b1, 32'hE0000291, 1'b1);
        checks++;
        if ({bus.issue_valid_o, bus.issue_instr_o, bus.stall_o, bus.instr_ready_o, bus.count_o} !== {1'b1, 32'hE0000291, 2'b10, 4'd3}) begin
            fails++;
            $display("FAIL mul_issue: got %h want issue e0000291 stall count 3", obs);
        end
        for (int i = 0; i < 3; i++) begin
            drive(1'b0, 32'h0, 1'b0);
            checks++;
            if (obs !== expv() || bus.count_o !== 4'(2 - i)) begin
                fails++;
                $display("FAIL mul_drain[%0d]: got %h want %h", i, obs, expv());
            end
        end
        drive(1'b1, 32'hE0000291, 1'b1);
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 32'hE0821003, 1'b1);
            checks++;
            if (obs !== expv()) begin
                fails++;
                $display("FAIL mul_backpressure[%0d]: got %h want %h", i, obs, expv());
            end
        end
        checks++;
        if ({bus.issue_valid_o, bus.issue_instr_o} !== {1'b1, 32'hE0821003}) begin
            fails++;
            $display("FAIL mul_held_issue: got %b %h want 1 e0821003", bus.issue_valid_o, bus.issue_instr_o);
        end
    endtask

    task automatic test_flush();
        drive(1'b1, 32'hE1A0F000, 1'b1);
        checks++;
        if (obs !== expv() || bus.flush_o !== 1'b1 || bus.count_o !== 4'd2) begin
            fails++;
            $display("FAIL flush_start: got %h want %h", obs, expv());
        end
        for (int i = 0; i < 2; i++) begin
            drive(1'b1, 32'hE0821003, 1'b1);
            checks++;
            if (obs !== expv() || bus.issue_valid_o !== 1'b0) begin
                fails++;
                $display("FAIL flush_discard[%0d]: got %h want %h", i, obs, expv());
            end
        end
        checks++;
        if (bus.flush_o !== 1'b0 || bus.instr_ready_o !== 1'b1) begin
            fails++;
            $display("FAIL flush_end: got flush %b ready %b want 0 1", bus.flush_o, bus.instr_ready_o);
        end
        drive(1'b0, 32'h0, 1'b0);
    endtask

    task automatic test_cond_fail();
        drive(1'b1, 32'h00000291, 1'b0);
        checks++;
        if (obs !== expv() || bus.issue_instr_o !== NOPI || bus.stall_o !== 1'b0) begin
            fails++;
            $display("FAIL cond_fail_mul: got %h want %h", obs, expv());
        end
        drive(1'b1, 32'h01A0F000, 1'b0);
        checks++;
        if (obs !== expv() || bus.flush_o !== 1'b0) begin
            fails++;
            $display("FAIL cond_fail_pcwrite: got %h want %h", obs, expv());
        end
    endtask

    task automatic test_other();
        drive(1'b1, 32'hE5912000, 1'b1);
        checks++;
        if (obs !== expv() || {bus.issue_valid_o, bus.issue_instr_o, bus.busy_o} !== {1'b1, NOPI, 1'b0}) begin
            fails++;
            $display("FAIL other_ldr: got %h want %h", obs, expv());
        end
        drive(1'b1, 32'hE00F0291, 1'b1);
        checks++;
        if (obs !== expv() || bus.stall_o !== 1'b1 || bus.flush_o !== 1'b0) begin
            fails++;
            $display("FAIL mul_rd15: got %h want %h", obs, expv());
        end
        for (int i = 0; i < MC - 1; i++) begin
            drive(1'b0, 32'h0, 1'b0);
            checks++;
            if (obs !== expv()) begin
                fails++;
                $display("FAIL mul_rd15_drain[%0d]: got %h want %h", i, obs, expv());
            end
        end
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 32'hE0821003 + 32'(i << 12), 1'b1);
            checks++;
            if (obs !== expv()) begin
                fails++;
                $display("FAIL back_to_back[%0d]: got %h want %h", i, obs, expv());
            end
        end
    endtask

    task automatic test_reset_abort();
        drive(1'b1, 32'hE0000291, 1'b1);
        drive(1'b0, 32'h0, 1'b0);
        checks++;
        if (bus.count_o !== 4'd2) begin
            fails++;
            $display("FAIL abort_setup: got count %0d want 2", bus.count_o);
        end
        #1 rst_n = 1'b0;
        #1 model_reset();
        checks++;
        if (obs !== {1'b0, NOPI, 4'b0001, 4'd0}) begin
            fails++;
            $display("FAIL abort_reset: got %h want %h", obs, {1'b0, NOPI, 4'b0001, 4'd0});
        end
        #1 rst_n = 1'b1;
        drive(1'b1, 32'hE0821003, 1'b1);
        checks++;
        if (obs !== expv() || bus.issue_instr_o !== 32'hE0821003) begin
            fails++;
            $display("FAIL abort_resume: got %h want %h", obs, expv());
        end
    endtask

    task automatic test_random();
        logic [31:0] r, ins;
        for (int i = 0; i < 400; i++) begin
            r = $urandom;
            case ($urandom_range(0, 4))
                0: ins = NOPI;
                1: ins = (r & ~32'h0E0000F0) | 32'h00000090;
                2: ins = r & ~32'h0C000000;
                3: ins = (r & ~32'h0C000000) | 32'h0000F000;
                default: ins = r;
            endcase
            drive($urandom_range(0, 3) != 0, ins, $urandom_range(0, 3) != 0);
            checks++;
            if (obs !== expv()) begin
                fails++;
                $display("FAIL random[%0d] instr %h: got %h want %h", i, ins, obs, expv());
            end
        end
    endtask

    initial begin
        test_reset();
        test_add();
        test_mul();
        test_flush();
        test_cond_fail();
        test_other();
        test_back_to_back();
        test_reset_abort();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule
